// File: rtl/sid_control_multi.sv
// Register-control block for 1..4 SID chips: rotating voice/filter register rings,
// per-chip pending-write buffers, read-only register access and data-bus value fade.
package sid;
    typedef struct packed {
        logic       phi2;
        logic       r_w_n;
        logic [4:0] addr;
        logic [7:0] data;
    } bus_i_t;

    typedef struct packed {
        logic [6:0][7:0] bytes;
    } voice_reg_t;

    typedef struct packed {
        logic [3:0][7:0] bytes;
    } filter_reg_t;

    // bytes[0..3] map to registers 0x19..0x1C (pot x, pot y, osc3, env3)
    typedef struct packed {
        logic [3:0][7:0] bytes;
    } misc_reg_t;

    localparam logic MOS6581 = 1'b0;
    localparam logic MOS8580 = 1'b1;
endpackage

module sid_control_multi #(
    parameter int         NUM_SIDS    = 2,
    parameter logic [9:0] TTL_MOS6581 = 10'd7,
    parameter logic [9:0] TTL_MOS8580 = 10'd664,
    localparam int        NV          = 3 * NUM_SIDS,
    localparam int        VW          = $clog2(NV),
    localparam int        FW          = (NUM_SIDS > 1) ? $clog2(NUM_SIDS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick_ms,
    input  sid::bus_i_t                   bus_i,
    input  logic [NUM_SIDS-1:0]           cs,
    input  logic [NUM_SIDS-1:0]           model,
    input  sid::misc_reg_t [NUM_SIDS-1:0] mreg,
    input  logic                          vrot,
    input  logic                          frot,
    output sid::voice_reg_t               voice_o,
    output logic [VW-1:0]                 voice_idx_o,
    output sid::filter_reg_t              filter_o,
    output logic [FW-1:0]                 filter_idx_o,
    output logic [7:0]                    data_o,
    output logic [NUM_SIDS-1:0]           wr_pending,
    output logic                          wr_drop
);

    function automatic logic [1:0] voice_of(input logic [4:0] a);
        if (a < 5'd7)       return 2'd0;
        else if (a < 5'd14) return 2'd1;
        else                return 2'd2;
    endfunction

    function automatic logic [2:0] vbyte_of(input logic [4:0] a);
        if (a < 5'd7)       return a[2:0];
        else if (a < 5'd14) return 3'(a - 5'd7);
        else                return 3'(a - 5'd14);
    endfunction

    function automatic logic [1:0] fbyte_of(input logic [4:0] a);
        return 2'(a - 5'h15);
    endfunction

    // Ring storage: index 0 is the head presented downstream.
    sid::voice_reg_t  r_vring [NV];
    sid::filter_reg_t r_fring [NUM_SIDS];
    logic [VW-1:0]    r_vidx;
    logic [FW-1:0]    r_fidx;

    logic [NUM_SIDS-1:0] r_pvalid;
    logic [4:0]          r_paddr [NUM_SIDS];
    logic [7:0]          r_pdata [NUM_SIDS];
    logic                r_drop;
    logic                r_w_q;

    logic [7:0] r_dbus [NUM_SIDS];
    logic [9:0] r_age  [NUM_SIDS];

    logic                w_w;
    logic                w_wr_acc;
    logic                w_rd;
    logic [1:0]          w_rd_off;
    logic [FW-1:0]       w_rd_chip_n;
    int                  w_rd_chip;
    logic [NUM_SIDS-1:0] w_vcommit;
    logic [NUM_SIDS-1:0] w_fcommit;
    logic [NUM_SIDS-1:0] w_iclear;
    logic [NUM_SIDS-1:0] w_done;
    sid::voice_reg_t     w_vhead;
    sid::filter_reg_t    w_fhead;
    logic [9:0]          w_ttl [NUM_SIDS];

    assign w_w      = ~bus_i.phi2 & ~bus_i.r_w_n;
    assign w_wr_acc = w_w & ~r_w_q;
    assign w_rd     = bus_i.phi2 & bus_i.r_w_n & (bus_i.addr >= 5'h19) & (bus_i.addr <= 5'h1C);
    assign w_rd_off = 2'(bus_i.addr - 5'h19);

    // Lowest set chip select wins; chip 0 when nothing is selected.
    always_comb begin
        w_rd_chip_n = '0;
        for (int c = NUM_SIDS - 1; c >= 0; c--) begin
            if (cs[c]) w_rd_chip_n = FW'(c);
        end
        w_rd_chip = int'(w_rd_chip_n);
    end

    always_comb begin
        data_o = r_dbus[w_rd_chip];
        if (w_rd && (|cs)) data_o = mreg[w_rd_chip].bytes[w_rd_off];
    end

    always_comb begin
        for (int c = 0; c < NUM_SIDS; c++) begin
            w_ttl[c] = model[c] ? TTL_MOS8580 : TTL_MOS6581;
        end
    end

    // At most one chip can target the current head index, so the byte
    // overrides below never collide.
    always_comb begin
        w_vcommit = '0;
        w_fcommit = '0;
        w_iclear  = '0;
        w_vhead   = r_vring[0];
        w_fhead   = r_fring[0];
        for (int c = 0; c < NUM_SIDS; c++) begin
            if (r_pvalid[c]) begin
                if (r_paddr[c] <= 5'h14) begin
                    if (vrot && (r_vidx == VW'(3 * c) + VW'(voice_of(r_paddr[c])))) begin
                        w_vcommit[c] = 1'b1;
                        w_vhead.bytes[vbyte_of(r_paddr[c])] = r_pdata[c];
                    end
                end else if (r_paddr[c] <= 5'h18) begin
                    if (frot && (r_fidx == FW'(c))) begin
                        w_fcommit[c] = 1'b1;
                        w_fhead.bytes[fbyte_of(r_paddr[c])] = r_pdata[c];
                    end
                end else begin
                    w_iclear[c] = 1'b1;
                end
            end
        end
        w_done = w_vcommit | w_fcommit | w_iclear;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NV; i++) r_vring[i] <= '0;
            for (int i = 0; i < NUM_SIDS; i++) begin
                r_fring[i]  <= '0;
                r_paddr[i]  <= '0;
                r_pdata[i]  <= '0;
                r_dbus[i]   <= '0;
                r_age[i]    <= '0;
            end
            r_vidx   <= '0;
            r_fidx   <= '0;
            r_pvalid <= '0;
            r_drop   <= 1'b0;
            r_w_q    <= 1'b0;
        end else begin
            r_w_q <= w_w;

            if (vrot) begin
                for (int i = 0; i < NV - 1; i++) r_vring[i] <= r_vring[i+1];
                r_vring[NV-1] <= w_vhead;
                r_vidx <= (r_vidx == VW'(NV - 1)) ? '0 : r_vidx + VW'(1);
            end

            if (frot) begin
                for (int i = 0; i < NUM_SIDS - 1; i++) r_fring[i] <= r_fring[i+1];
                r_fring[NUM_SIDS-1] <= w_fhead;
                r_fidx <= (r_fidx == FW'(NUM_SIDS - 1)) ? '0 : r_fidx + FW'(1);
            end

            for (int c = 0; c < NUM_SIDS; c++) begin
                // A capture coinciding with a commit is not a drop: the old
                // entry leaves through the commit this same cycle.
                if (w_wr_acc && cs[c]) begin
                    if (r_pvalid[c] && !w_done[c]) r_drop <= 1'b1;
                    r_pvalid[c] <= 1'b1;
                    r_paddr[c]  <= bus_i.addr;
                    r_pdata[c]  <= bus_i.data;
                end else if (w_done[c]) begin
                    r_pvalid[c] <= 1'b0;
                end

                if (cs[c] && (w_rd || w_wr_acc)) begin
                    r_dbus[c] <= w_rd ? mreg[c].bytes[w_rd_off] : bus_i.data;
                    r_age[c]  <= '0;
                end else if (r_age[c] == w_ttl[c]) begin
                    r_dbus[c] <= '0;
                end else if (tick_ms) begin
                    r_age[c] <= r_age[c] + 10'd1;
                end
            end
        end
    end

    assign voice_o      = r_vring[0];
    assign voice_idx_o  = r_vidx;
    assign filter_o     = r_fring[0];
    assign filter_idx_o = r_fidx;
    assign wr_pending   = r_pvalid;
    assign wr_drop      = r_drop;

endmodule

// File: tb/tb_sid_control_multi.sv
// Bench for sid_control_multi (two chips): reference model keeps registers indexed by
// voice/chip number; every cycle the expected observation is queued and checked by a monitor.
module tb_sid_control_multi;
    localparam int NS  = 2;
    localparam int NV  = 3 * NS;
    localparam int VW  = $clog2(NV);
    localparam int FW  = 1;
    localparam int OW  = 56 + VW + 32 + FW + 8 + NS + 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    tick_ms;
    sid::bus_i_t             bus_i;
    logic [NS-1:0]           cs;
    logic [NS-1:0]           model;
    sid::misc_reg_t [NS-1:0] mreg;
    logic                    vrot;
    logic                    frot;
    sid::voice_reg_t         voice_o;
    logic [VW-1:0]           voice_idx_o;
    sid::filter_reg_t        filter_o;
    logic [FW-1:0]           filter_idx_o;
    logic [7:0]              data_o;
    logic [NS-1:0]           wr_pending;
    logic                    wr_drop;

    sid_control_multi #(.NUM_SIDS(NS)) dut (
        .clk(clk), .rst(rst), .tick_ms(tick_ms), .bus_i(bus_i), .cs(cs),
        .model(model), .mreg(mreg), .vrot(vrot), .frot(frot),
        .voice_o(voice_o), .voice_idx_o(voice_idx_o), .filter_o(filter_o),
        .filter_idx_o(filter_idx_o), .data_o(data_o), .wr_pending(wr_pending),
        .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    logic [OW-1:0] exp_q[$];
    string         name_q[$];
    int            n_chk = 0;
    int            n_pass = 0;
    logic          chk_valid = 1'b0;
    string         cur_name = "reset";

    // Reference model: registers addressed by global voice index / chip number.
    logic [7:0] m_v [NV][7];
    logic [7:0] m_f [NS][4];
    int         m_vidx, m_fidx;
    bit         m_pv [NS];
    logic [4:0] m_pa [NS];
    logic [7:0] m_pd [NS];
    bit         m_drop;
    logic [7:0] m_dv [NS];
    int         m_age [NS];
    bit         m_wq;

    function automatic int low_chip();
        for (int c = 0; c < NS; c++) if (cs[c]) return c;
        return 0;
    endfunction

    function automatic bit is_read();
        return bus_i.phi2 && bus_i.r_w_n && bus_i.addr >= 5'h19 && bus_i.addr <= 5'h1C;
    endfunction

    function automatic logic [OW-1:0] expected();
        logic [55:0]   v;
        logic [31:0]   f;
        logic [7:0]    d;
        logic [NS-1:0] p;
        logic [VW-1:0] vi;
        logic [FW-1:0] fi;
        int lc;
        for (int b = 0; b < 7; b++) v[b*8 +: 8] = m_v[m_vidx][b];
        for (int b = 0; b < 4; b++) f[b*8 +: 8] = m_f[m_fidx][b];
        for (int c = 0; c < NS; c++) p[c] = m_pv[c];
        lc = low_chip();
        if (is_read() && cs != 0) d = mreg[lc].bytes[int'(bus_i.addr) - 'h19];
        else d = m_dv[lc];
        vi = m_vidx[VW-1:0];
        fi = m_fidx[FW-1:0];
        return {v, vi, f, fi, d, p, m_drop};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) for (int b = 0; b < 7; b++) m_v[i][b] = 8'h00;
        for (int c = 0; c < NS; c++) begin
            for (int b = 0; b < 4; b++) m_f[c][b] = 8'h00;
            m_pv[c] = 0; m_pa[c] = '0; m_pd[c] = '0; m_dv[c] = '0; m_age[c] = 0;
        end
        m_vidx = 0; m_fidx = 0; m_drop = 0; m_wq = 0;
    endtask

    task automatic model_step();
        bit w, acc, r;
        bit done [NS];
        int a, ttl;
        if (rst) begin
            model_reset();
            return;
        end
        w   = !bus_i.phi2 && !bus_i.r_w_n;
        acc = w && !m_wq;
        r   = is_read();
        for (int c = 0; c < NS; c++) begin
            done[c] = 0;
            if (m_pv[c]) begin
                a = int'(m_pa[c]);
                if (a <= 'h14) begin
                    if (vrot && m_vidx == 3 * c + a / 7) begin
                        m_v[m_vidx][a % 7] = m_pd[c];
                        done[c] = 1;
                    end
                end else if (a <= 'h18) begin
                    if (frot && m_fidx == c) begin
                        m_f[c][a - 'h15] = m_pd[c];
                        done[c] = 1;
                    end
                end else begin
                    done[c] = 1;
                end
            end
        end
        for (int c = 0; c < NS; c++) begin
            if (acc && cs[c]) begin
                if (m_pv[c] && !done[c]) m_drop = 1;
                m_pv[c] = 1; m_pa[c] = bus_i.addr; m_pd[c] = bus_i.data;
            end else if (done[c]) begin
                m_pv[c] = 0;
            end
            ttl = model[c] ? 664 : 7;
            if (cs[c] && (r || acc)) begin
                m_dv[c]  = r ? mreg[c].bytes[int'(bus_i.addr) - 'h19] : bus_i.data;
                m_age[c] = 0;
            end else if (m_age[c] == ttl) begin
                m_dv[c] = 8'h00;
            end else if (tick_ms) begin
                m_age[c]++;
            end
        end
        if (vrot) m_vidx = (m_vidx + 1) % NV;
        if (frot) m_fidx = (m_fidx + 1) % NS;
        m_wq = w;
    endtask

    // Monitor: compares the DUT observation against the queued expectation.
    always @(negedge clk) begin
        logic [OW-1:0] act, exp_v;
        string nm;
        if (chk_valid) begin
            act = {voice_o, voice_idx_o, filter_o, filter_idx_o, data_o, wr_pending, wr_drop};
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL %s: observation with empty expected queue, got %h", cur_name, act);
            end else begin
                exp_v = exp_q.pop_front();
                nm = name_q.pop_front();
                if (act === exp_v) n_pass++;
                else $display("FAIL %s @%0t: got %h required %h", nm, $time, act, exp_v);
            end
        end
    end

    task automatic cycle(input bit chk);
        if (chk) begin
            exp_q.push_back(expected());
            name_q.push_back(cur_name);
            chk_valid = 1'b1;
        end
        @(posedge clk);
        model_step();
        #1;
        chk_valid = 1'b0;
    endtask

    task automatic bus_idle();
        bus_i.phi2 = 1'b0; bus_i.r_w_n = 1'b1; bus_i.addr = 5'h00; bus_i.data = 8'h00;
    endtask

    task automatic bus_write(input logic [NS-1:0] sel, input logic [4:0] a, input logic [7:0] d);
        cs = sel;
        bus_i.phi2 = 1'b0; bus_i.r_w_n = 1'b0; bus_i.addr = a; bus_i.data = d;
        cycle(1);
        bus_idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(0);
        cycle(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick_ms = 1'b0; cs = '0; model = '0; vrot = 1'b0; frot = 1'b0;
        for (int c = 0; c < NS; c++) mreg[c] = 32'($urandom);
        bus_idle();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        cur_name = "voice_commit";
        vrot = 1'b1;
        bus_write(2'b01, 5'h08, 8'h42);
        repeat (14) cycle(1);
        vrot = 1'b0;

        cur_name = "filter_both";
        frot = 1'b1;
        bus_write(2'b11, 5'h16, 8'h17);
        repeat (6) cycle(1);
        frot = 1'b0;
        vrot = 1'b1;
        repeat (7) cycle(1);
        vrot = 1'b0;

        cur_name = "write_drop";
        bus_write(2'b01, 5'h02, 8'hA1);
        cycle(1);
        bus_write(2'b01, 5'h02, 8'hB2);
        repeat (3) cycle(1);
        vrot = 1'b1;
        repeat (14) cycle(1);
        vrot = 1'b0;

        cur_name = "fade_6581";
        do_reset();
        model = {sid::MOS6581, sid::MOS6581};
        bus_write(2'b01, 5'h1D, 8'h5A);
        cs = 2'b01;
        repeat (9) begin
            tick_ms = 1'b1; cycle(1);
            tick_ms = 1'b0; cycle(1); cycle(1);
        end

        cur_name = "fade_8580";
        model = {sid::MOS6581, sid::MOS8580};
        bus_write(2'b01, 5'h1E, 8'h5A);
        cs = 2'b01;
        repeat (670) begin
            tick_ms = 1'b1; cycle(1);
            tick_ms = 1'b0; cycle(1);
        end

        cur_name = "read_osc3";
        mreg[1] = 32'h11_9C_22_33;
        cs = 2'b10;
        bus_i.phi2 = 1'b1; bus_i.r_w_n = 1'b1; bus_i.addr = 5'h1B;
        cycle(1);
        bus_idle();
        repeat (3) cycle(1);

        cur_name = "reset_midop";
        do_reset();
        vrot = 1'b1; cycle(1);
        vrot = 1'b0;
        bus_write(2'b01, 5'h00, 8'h77);
        vrot = 1'b1; repeat (3) cycle(1);
        vrot = 1'b0;
        rst = 1'b1; cycle(1);
        rst = 1'b0;
        repeat (3) cycle(1);

        cur_name = "random";
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 299) == 0);
            tick_ms = ($urandom_range(0, 3) == 0);
            vrot    = 1'($urandom_range(0, 1));
            frot    = 1'($urandom_range(0, 1));
            cs      = NS'($urandom_range(0, 3));
            if (n % 250 == 0) model = NS'($urandom_range(0, 3));
            for (int c = 0; c < NS; c++) mreg[c] = 32'($urandom);
            bus_i.phi2  = 1'($urandom_range(0, 1));
            bus_i.r_w_n = 1'($urandom_range(0, 1));
            bus_i.addr  = 5'($urandom_range(0, 31));
            bus_i.data  = 8'($urandom);
            cycle(1);
        end
        rst = 1'b0;
        bus_idle();

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sid_control_multi.md
# sid_control_multi

Parametrised register-control block for 1–4 SID chips, the multi-chip successor to the two-chip control block.
- Keeps every chip's write-only voice and filter registers in rotating rings, so downstream voice/filter pipelines read one voice or filter set per rotation step.
- Decouples bus writes from ring position through a per-chip pending-write buffer.
- Serves the read-only registers and models per-chip data-bus value fade.

## Interface
Parameters:
- NUM_SIDS, 2, number of emulated chips (1..4); voice ring depth NV = 3*NUM_SIDS, filter ring depth NUM_SIDS.
- TTL_MOS6581, 10'd7, bus value fade time in ms for 6581.
- TTL_MOS8580, 10'd664, bus value fade time in ms for 8580.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- tick_ms  in  1  one-cycle strobe every millisecond.
- bus_i  in  sid::bus_i_t  phi2, r_w_n, addr[4:0], data[7:0].
- cs  in  NUM_SIDS  chip selects, bit c = chip c.
- model  in  NUM_SIDS  per-chip model, sid::MOS6581 / sid::MOS8580.
- mreg  in  NUM_SIDS x sid::misc_reg_t  per-chip read-only registers (bytes 0x19..0x1C).
- vrot  in  1  rotate voice ring this cycle.
- frot  in  1  rotate filter ring this cycle.
- voice_o  out  sid::voice_reg_t  voice set at ring head.
- voice_idx_o  out  $clog2(NV)  global voice index at head (chip*3 + voice).
- filter_o  out  sid::filter_reg_t  filter set at ring head.
- filter_idx_o  out  $clog2(NUM_SIDS)  chip index at filter head (0 when NUM_SIDS=1).
- data_o  out  8  read data.
- wr_pending  out  NUM_SIDS  per-chip write buffer occupied.
- wr_drop  out  1  sticky, a pending write was overwritten before commit.

## Operation
- Address decode per chip:
  - 0x00–0x14: voice writes; voice = addr/7, byte = addr%7.
  - 0x15–0x18: filter writes.
  - 0x19–0x1C: reads.
  - 0x1D–0x1F: writes ignored for registers but still latched on the data bus.
- Write strobe: w = ~phi2 & ~r_w_n.
  - A write is accepted only on the first clk of a w assertion (rising edge of w, registered w_q).
  - Each chip c with cs[c]=1 captures {addr, data} into its pending entry and sets wr_pending[c].
- Write commit, voice:
  - Condition: vrot=1, pending entry is a voice address, and voice_idx_o == 3c + voice.
  - The head set is written into the ring tail with the target byte replaced; wr_pending[c] clears.
- Write commit, filter: same rule with frot and filter_idx_o == c.
- Pending ignored addresses (0x19–0x1F) clear on the next clk without touching the rings.
- Rotation: each vrot rotates the voice ring by one. ring[NV-1] <= head (possibly modified); voice_idx_o increments, wrapping NV-1 -> 0. Filter ring rotates identically on frot.
- New write while wr_pending[c]=1: the new write replaces the entry and wr_drop sets. wr_drop clears only on rst.
- Read: r = phi2 & r_w_n & addr in 0x19..0x1C.
  - Read chip = lowest set bit of cs.
  - data_o = mreg[chip].bytes[addr-0x19] when r and |cs; otherwise data_o = dbus value of that chip.
  - With cs=0, data_o = dbus value of chip 0.
- Bus fade, per chip c, in priority order:
  1. rst: value 0, age 0.
  2. cs[c] & (r | accepted write): value <= read or written byte, age <= 0.
  3. age == TTL(model[c]): value <= 0; age holds.
  4. tick_ms: age <= age + 1.

## Timing
- Reset values:
  - Both rings all zero; voice_idx_o=0, filter_idx_o=0.
  - voice_o and filter_o all zero.
  - wr_pending=0, wr_drop=0, data_o=0, all dbus values and ages 0.
- Write capture: wr_pending[c] rises 1 clk after the w edge.
- Commit latency: at most NV vrot cycles (voice) or NUM_SIDS frot cycles (filter).
  - Data is visible on voice_o the next time that index reaches head: NV vrot cycles after commit.
  - Without vrot/frot the entry stays pending indefinitely.
- Capture and commit of the same chip in the same clk: the commit uses the old entry, and the new entry stays pending with wr_drop unchanged.
- rst mid-operation discards all pending writes and resets ring position.
- data_o on reads is combinational from bus_i/mreg, zero cycles.
- Fade: value clears exactly TTL tick_ms strobes after the last access.

## Test plan
- NUM_SIDS=2, write 0x42 to addr 0x08 (voice 1 byte 1) with cs=01 and vrot constant -> commit when voice_idx_o=1; voice_o byte 1 = 0x42 when idx 1 returns 6 cycles later; wr_pending returns 0.
- cs=11, write 0x17 to addr 0x16 -> both chips' filter byte 1 = 0x17 after frot visits idx 0 and 1; chip 1 voice registers untouched.
- Two writes to chip 0 while vrot=0 -> wr_drop=1; only the second write appears after vrot resumes.
- Write 0x5A to chip 0 with model 6581, issue 7 tick_ms -> data_o (cs=01, no read) 0x5A through tick 6, 0x00 after tick 7; with 8580 it holds until 664 ticks.
- Read addr 0x1B with cs=10, mreg[1] osc3=0x9C -> data_o=0x9C same cycle; chip 1 dbus value becomes 0x9C.
- Assert rst with a write pending and idx=4 -> next clk: wr_pending=0, voice_idx_o=0, voice_o=0, data_o=0.
